instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/project_pkg.sv | 12 +
 rtl/instr_ram.sv | 40 ++++
 rtl/instr_fetch.sv | 76 +++++++
 3 files changed

// File: rtl/project_pkg.sv
// Project-wide constants and shared types for the instruction fetch path.
package project_pkg;

    localparam int word_length = 8;
    localparam int ROM_DEPTH   = 256;

    typedef enum logic {
        FETCH_IDLE  = 1'b0,
        FETCH_VALID = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/instr_ram.sv
// Program storage: one write port and two registered read ports at addr and addr+1.
module instr_ram
    import project_pkg::*;
#(
    parameter int WORD_W = word_length,
    parameter int DEPTH  = ROM_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WORD_W-1:0] rdata0_o,
    output logic [WORD_W-1:0] rdata1_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rd0_q;
    logic [WORD_W-1:0] rd1_q;
    logic [ADDR_W-1:0] raddr_nxt;

    // Carry out of the top bit is dropped so the last word pairs with word 0.
    assign raddr_nxt = raddr_i + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rd0_q <= mem_q[raddr_i];
            rd1_q <= mem_q[raddr_nxt];
        end
    end

    assign rdata0_o = rd0_q;
    assign rdata1_o = rd1_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front end: request/response handshake around instr_ram.
module instr_fetch
    import project_pkg::*;
#(
    parameter int WORD_W = word_length,
    parameter int DEPTH  = ROM_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_instr,
    output logic [WORD_W-1:0] rsp_imm,
    output logic [ADDR_W-1:0] rsp_addr,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [WORD_W-1:0] prog_data
);

    fetch_state_t      state_q;
    logic              rsp_valid_q;
    logic [ADDR_W-1:0] rsp_addr_q;
    logic              loaded_q;
    logic              accept;
    logic [WORD_W-1:0] ram_instr;
    logic [WORD_W-1:0] ram_imm;

    assign req_ready = !prog_we && (state_q == FETCH_IDLE || rsp_ready);
    assign accept    = req_valid && req_ready;

    instr_ram #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk      (clk),
        .we_i     (prog_we),
        .waddr_i  (prog_addr),
        .wdata_i  (prog_data),
        .re_i     (accept),
        .raddr_i  (req_addr),
        .rdata0_o (ram_instr),
        .rdata1_o (ram_imm)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FETCH_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            loaded_q    <= 1'b0;
        end else begin
            if (accept) begin
                state_q     <= FETCH_VALID;
                rsp_valid_q <= 1'b1;
                rsp_addr_q  <= req_addr;
                loaded_q    <= 1'b1;
            end else if (state_q == FETCH_VALID && rsp_ready) begin
                state_q     <= FETCH_IDLE;
                rsp_valid_q <= 1'b0;
            end
        end
    end

    // The RAM read registers double as the data output registers; they have no
    // reset, so the data is gated to zero until the first fetch after reset.
    assign rsp_valid = rsp_valid_q;
    assign rsp_addr  = rsp_addr_q;
    assign rsp_instr = loaded_q ? ram_instr : '0;
    assign rsp_imm   = loaded_q ? ram_imm   : '0;

endmodule
